// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks.
//   ser_state_t       : serializer FSM states (IDLE waits for a vector,
//                       SHIFT streams the held vector out element by element)
//   DEF_NUM_NEURONS   : default number of neuron outputs per layer vector
//   DEF_DATA_WIDTH    : default bits per neuron output
package nn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int DEF_NUM_NEURONS = 16;
    localparam int DEF_DATA_WIDTH  = 8;

endpackage

// File: rtl/element_counter.sv
// Element index counter for the layer output serializer.
// Counts accepted elements 0..numNeurons-1 and wraps back to 0 after the
// last one, so the next vector always starts at index 0.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset, forces count to 0
//   inc   : advance by one element this edge
//   count : current element index
//   last  : count is at numNeurons-1
module element_counter #(
    parameter int numNeurons = 16,
    parameter int indexWidth = $clog2(numNeurons)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [indexWidth-1:0] count,
    output logic                  last
);

    localparam logic [indexWidth-1:0] LAST_IDX = indexWidth'(numNeurons - 1);

    logic [indexWidth-1:0] count_q;
    logic [indexWidth-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = (count_q == LAST_IDX) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_IDX);

endmodule

// File: rtl/layer_output_serializer.sv
// Layer output serializer: captures a parallel vector of neuron outputs and
// streams it element by element (index 0 first) over a valid/ready link.
// A new vector may be accepted on the same edge the last element transfers,
// so back-to-back vectors stream without a bubble.
//   clk            : clock, rising edge
//   reset          : asynchronous active-high reset
//   layerIn        : parallel vector, element k at [k*dataWidth +: dataWidth]
//   layerInValid   : layerIn holds a complete vector
//   layerInReady   : vector accepted this edge if layerInValid (combinational)
//   serialOut      : current element (0 when not valid)
//   serialOutValid : serialOut holds a valid element
//   serialReady    : downstream accepts the element
//   serialIndex    : index of the element on serialOut
//   serialLast     : element on serialOut is the last one
//   busy           : a vector is held and not yet fully transferred
//   overrun        : sticky, a vector was offered while not ready
module layer_output_serializer
    import nn_pkg::*;
#(
    parameter int numNeurons = DEF_NUM_NEURONS,
    parameter int dataWidth  = DEF_DATA_WIDTH,
    parameter int indexWidth = $clog2(numNeurons)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [numNeurons*dataWidth-1:0]  layerIn,
    input  logic                             layerInValid,
    output logic                             layerInReady,
    output logic [dataWidth-1:0]             serialOut,
    output logic                             serialOutValid,
    input  logic                             serialReady,
    output logic [indexWidth-1:0]            serialIndex,
    output logic                             serialLast,
    output logic                             busy,
    output logic                             overrun
);

    localparam int VEC_W = numNeurons * dataWidth;

    ser_state_t         state_q;
    ser_state_t         state_d;
    logic [VEC_W-1:0]   storage_q;
    logic [VEC_W-1:0]   storage_d;
    logic               overrun_q;
    logic               overrun_d;

    logic               out_valid;
    logic               transfer;
    logic               in_ready;
    logic               capture;
    logic [indexWidth-1:0] cnt_index;
    logic               cnt_last;

    element_counter #(
        .numNeurons (numNeurons),
        .indexWidth (indexWidth)
    ) u_element_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (transfer),
        .count (cnt_index),
        .last  (cnt_last)
    );

    always_comb begin
        out_valid = (state_q == SHIFT);
        transfer  = out_valid && serialReady;
        // Ready while idle, or when the last element leaves this edge.
        in_ready  = (state_q == IDLE) || (out_valid && cnt_last && serialReady);
        capture   = layerInValid && in_ready;

        state_d   = state_q;
        storage_d = storage_q;
        overrun_d = overrun_q | (layerInValid & ~in_ready);

        if (capture) begin
            storage_d = layerIn;
            state_d   = SHIFT;
        end else if (transfer) begin
            // Element 0 always sits in the low slice; shift the next one down.
            storage_d = storage_q >> dataWidth;
            if (cnt_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            storage_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            storage_q <= storage_d;
            overrun_q <= overrun_d;
        end
    end

    assign layerInReady   = in_ready;
    assign serialOutValid = out_valid;
    assign serialOut      = out_valid ? storage_q[dataWidth-1:0] : '0;
    assign serialIndex    = cnt_index;
    assign serialLast     = out_valid && cnt_last;
    assign busy           = out_valid;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
module tb_layer_output_serializer;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*DW-1:0]   layerIn;
    logic              layerInValid;
    logic              layerInReady;
    logic [DW-1:0]     serialOut;
    logic              serialOutValid;
    logic              serialReady;
    logic [IW-1:0]     serialIndex;
    logic              serialLast;
    logic              busy;
    logic              overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    layer_output_serializer #(
        .numNeurons (N),
        .dataWidth  (DW),
        .indexWidth (IW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .layerIn        (layerIn),
        .layerInValid   (layerInValid),
        .layerInReady   (layerInReady),
        .serialOut      (serialOut),
        .serialOutValid (serialOutValid),
        .serialReady    (serialReady),
        .serialIndex    (serialIndex),
        .serialLast     (serialLast),
        .busy           (busy),
        .overrun        (overrun)
    );

    // Vector whose element k is base+k.
    function automatic logic [N*DW-1:0] mk_vec(input logic [7:0] base);
        logic [N*DW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = base + 8'(k);
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; layerIn = '0; layerInValid = 1'b0; serialReady = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({serialOutValid, serialIndex, serialOut, serialLast, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b i=%0d o=%h l=%b b=%b ov=%b exp all 0",
                     serialOutValid, serialIndex, serialOut, serialLast, busy, overrun);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (layerInReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready got=%b exp=1", layerInReady);
        end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        @(negedge clk);
        layerIn = mk_vec(8'h01); layerInValid = 1'b1; serialReady = 1'b1;
        #1;
        checks++;
        if (layerInReady !== 1'b1) begin
            errors++;
            $display("FAIL stream_capture_ready got=%b exp=1", layerInReady);
        end
        @(negedge clk);
        layerInValid = 1'b0; layerIn = '0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({serialOutValid, serialIndex, serialOut, serialLast, busy} !==
                {1'b1, IW'(k), 8'(k + 1), (k == N - 1), 1'b1}) begin
                errors++;
                $display("FAIL stream_elem k=%0d got v=%b i=%0d o=%h l=%b b=%b exp v=1 i=%0d o=%h l=%b b=1",
                         k, serialOutValid, serialIndex, serialOut, serialLast, busy,
                         k, 8'(k + 1), (k == N - 1));
            end
            @(negedge clk);
        end
        checks++;
        if ({serialOutValid, serialOut, serialIndex, busy, layerInReady} !== {1'b0, 8'h00, 4'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stream_idle_after got v=%b o=%h i=%0d b=%b rdy=%b exp v=0 o=00 i=0 b=0 rdy=1",
                     serialOutValid, serialOut, serialIndex, busy, layerInReady);
        end
        $display("test_stream done");
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int e;
        int cyc;
        pat = 4'b1001;  // ready sequence 1,0,0,1 (bit 3 first)
        e = 0;
        cyc = 0;
        @(negedge clk);
        layerIn = mk_vec(8'h01); layerInValid = 1'b1; serialReady = 1'b0;
        @(negedge clk);
        layerInValid = 1'b0;
        while (e < N && cyc < 200) begin
            serialReady = pat[3 - (cyc % 4)];
            checks++;
            if ({serialOutValid, serialIndex, serialOut} !== {1'b1, IW'(e), 8'(e + 1)}) begin
                errors++;
                $display("FAIL bp_elem cyc=%0d got v=%b i=%0d o=%h exp v=1 i=%0d o=%h",
                         cyc, serialOutValid, serialIndex, serialOut, e, 8'(e + 1));
            end
            if (serialReady) e++;
            cyc++;
            @(negedge clk);
        end
        serialReady = 1'b1;
        checks++;
        if (e != N || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_complete got elems=%0d busy=%b exp elems=%0d busy=0", e, busy, N);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        layerIn = mk_vec(8'h01); layerInValid = 1'b1; serialReady = 1'b1;
        @(negedge clk);
        layerInValid = 1'b0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({serialIndex, serialOut} !== {IW'(k), 8'(k + 1)}) begin
                errors++;
                $display("FAIL b2b_first k=%0d got i=%0d o=%h exp i=%0d o=%h",
                         k, serialIndex, serialOut, k, 8'(k + 1));
            end
            if (k == N - 1) begin
                layerIn = mk_vec(8'hA0); layerInValid = 1'b1;
                #1;
                checks++;
                if (layerInReady !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_last_ready got=%b exp=1", layerInReady);
                end
            end
            @(negedge clk);
        end
        layerInValid = 1'b0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({serialOutValid, serialIndex, serialOut, overrun} !== {1'b1, IW'(k), 8'hA0 + 8'(k), 1'b0}) begin
                errors++;
                $display("FAIL b2b_second k=%0d got v=%b i=%0d o=%h ov=%b exp v=1 i=%0d o=%h ov=0",
                         k, serialOutValid, serialIndex, serialOut, overrun, k, 8'hA0 + 8'(k));
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got busy=%b exp=0", busy);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_overrun();
        @(negedge clk);
        layerIn = mk_vec(8'h01); layerInValid = 1'b1; serialReady = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            layerIn = mk_vec(8'hA0);
            layerInValid = (k == 5);
            #1;
            checks++;
            if ({serialIndex, serialOut, overrun} !== {IW'(k), 8'(k + 1), (k > 5)}) begin
                errors++;
                $display("FAIL ovr_elem k=%0d got i=%0d o=%h ov=%b exp i=%0d o=%h ov=%b",
                         k, serialIndex, serialOut, overrun, k, 8'(k + 1), (k > 5));
            end
            if (k == 5) begin
                checks++;
                if (layerInReady !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_ready got=%b exp=0", layerInReady);
                end
            end
            @(negedge clk);
        end
        layerInValid = 1'b0;
        checks++;
        if ({overrun, busy} !== 2'b10) begin
            errors++;
            $display("FAIL ovr_sticky got ov=%b busy=%b exp ov=1 busy=0", overrun, busy);
        end
        $display("test_overrun done");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        layerIn = mk_vec(8'h01); layerInValid = 1'b1; serialReady = 1'b1;
        @(negedge clk);
        layerInValid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({serialIndex, serialOut} !== {IW'(k), 8'(k + 1)}) begin
                errors++;
                $display("FAIL rst_mid_pre k=%0d got i=%0d o=%h exp i=%0d o=%h",
                         k, serialIndex, serialOut, k, 8'(k + 1));
            end
            if (k < 7) @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({serialOutValid, serialIndex, serialOut, serialLast, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async got v=%b i=%0d o=%h l=%b b=%b ov=%b exp all 0",
                     serialOutValid, serialIndex, serialOut, serialLast, busy, overrun);
        end
        @(negedge clk);
        reset = 1'b0;
        layerIn = mk_vec(8'hA0); layerInValid = 1'b1;
        @(negedge clk);
        layerInValid = 1'b0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({serialOutValid, serialIndex, serialOut, overrun} !== {1'b1, IW'(k), 8'hA0 + 8'(k), 1'b0}) begin
                errors++;
                $display("FAIL rst_mid_next k=%0d got v=%b i=%0d o=%h ov=%b exp v=1 i=%0d o=%h ov=0",
                         k, serialOutValid, serialIndex, serialOut, overrun, k, 8'hA0 + 8'(k));
            end
            @(negedge clk);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
